// File: rtl/tetris_draw_pkg.sv
// Shared definitions for the board draw path: cell code width, palette, default geometry, FSM.
package tetris_draw_pkg;

    localparam int unsigned CODE_W = 3;

    localparam logic [8:0] PAL_0 = 9'h000;  // black (empty)
    localparam logic [8:0] PAL_1 = 9'h03F;  // cyan
    localparam logic [8:0] PAL_2 = 9'h1F8;  // yellow
    localparam logic [8:0] PAL_3 = 9'h104;  // purple
    localparam logic [8:0] PAL_4 = 9'h038;  // green
    localparam logic [8:0] PAL_5 = 9'h1C0;  // red
    localparam logic [8:0] PAL_6 = 9'h007;  // blue
    localparam logic [8:0] PAL_7 = 9'h1E0;  // orange

    localparam int unsigned COLS   = 10;
    localparam int unsigned ROWS   = 20;
    localparam int unsigned CELL_W = 64;
    localparam int unsigned CELL_H = 24;

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StLatch,
        StStart,
        StWait,
        StNext,
        StDone
    } draw_state_e;

endpackage

// File: rtl/cell_palette.sv
// Combinational map from a 3-bit cell code to its 9-bit RRRGGGBBB colour.
module cell_palette
    import tetris_draw_pkg::*;
(
    input  logic [CODE_W-1:0] code_i,
    output logic [8:0]        color_o
);

    always_comb begin
        color_o = PAL_0;
        unique case (code_i)
            3'd0: color_o = PAL_0;
            3'd1: color_o = PAL_1;
            3'd2: color_o = PAL_2;
            3'd3: color_o = PAL_3;
            3'd4: color_o = PAL_4;
            3'd5: color_o = PAL_5;
            3'd6: color_o = PAL_6;
            3'd7: color_o = PAL_7;
            default: color_o = PAL_0;
        endcase
    end

endmodule

// File: rtl/up_counter.sv
// Loadable up-counter; load has priority over increment.
module up_counter #(
    parameter int unsigned Width = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [Width-1:0] load_val_i,
    input  logic             en_i,
    output logic [Width-1:0] q_o
);

    logic [Width-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i) begin
            cnt_d = cnt_q + Width'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q_o = cnt_q;

endmodule

// File: rtl/board_draw_sequencer.sv
// Walks the playfield RAM and issues one box-draw command per cell, waiting on box_done.
// Optional SKIP_UNCHANGED_EN: skip cells whose code matches the last drawn value.
module board_draw_sequencer #(
    parameter int unsigned COLS     = tetris_draw_pkg::COLS,
    parameter int unsigned ROWS     = tetris_draw_pkg::ROWS,
    parameter int unsigned CELL_W   = tetris_draw_pkg::CELL_W,
    parameter int unsigned CELL_H   = tetris_draw_pkg::CELL_H,
    parameter logic [9:0]  X_ORIGIN = 10'd0,
    parameter logic [8:0]  Y_ORIGIN = 9'd0
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic       refresh,
    output logic [7:0] rd_addr,
    input  logic [2:0] rd_data,
    output logic       box_start,
    output logic [9:0] box_x0,
    output logic [8:0] box_y0,
    output logic [8:0] box_color,
    input  logic       box_done,
    output logic       busy,
    output logic       frame_done
);
    import tetris_draw_pkg::*;

    localparam int unsigned ColW = $clog2(COLS);
    localparam int unsigned RowW = $clog2(ROWS);

    draw_state_e state_q, state_d;
    logic [7:0]  addr_q, addr_d;
    logic [9:0]  x_q, x_d;
    logic [8:0]  y_q, y_d;
    logic [8:0]  color_q, color_d;
    logic        pending_q, pending_d;
    logic [8:0]  pal_color;
    logic [ColW-1:0] col_q;
    logic [RowW-1:0] row_q;
    logic        col_load, col_en, row_load, row_en;
    logic        last_cell;

`ifdef SKIP_UNCHANGED_EN
    logic [CODE_W-1:0] shadow_q [ROWS*COLS];
    logic              shadow_valid_q, shadow_valid_d;
    logic              shadow_we;
`endif

    cell_palette u_palette (
        .code_i  (rd_data),
        .color_o (pal_color)
    );

    up_counter #(.Width(ColW)) u_col_cnt (
        .clk_i      (CLOCK_50),
        .rst_ni     (resetn),
        .load_i     (col_load),
        .load_val_i ('0),
        .en_i       (col_en),
        .q_o        (col_q)
    );

    up_counter #(.Width(RowW)) u_row_cnt (
        .clk_i      (CLOCK_50),
        .rst_ni     (resetn),
        .load_i     (row_load),
        .load_val_i ('0),
        .en_i       (row_en),
        .q_o        (row_q)
    );

    assign last_cell = (col_q == ColW'(COLS - 1)) && (row_q == RowW'(ROWS - 1));

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        x_d       = x_q;
        y_d       = y_q;
        color_d   = color_q;
        // Requests arriving mid-frame merge into one follow-up frame.
        pending_d = pending_q | (refresh && (state_q != StIdle));
        col_load  = 1'b0;
        col_en    = 1'b0;
        row_load  = 1'b0;
        row_en    = 1'b0;
`ifdef SKIP_UNCHANGED_EN
        shadow_valid_d = shadow_valid_q;
        shadow_we      = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                if (refresh || pending_q) begin
                    col_load  = 1'b1;
                    row_load  = 1'b1;
                    addr_d    = '0;
                    x_d       = X_ORIGIN;
                    y_d       = Y_ORIGIN;
                    pending_d = 1'b0;
                    state_d   = StAddr;
                end
            end
            StAddr: state_d = StLatch;
            StLatch: begin
`ifdef SKIP_UNCHANGED_EN
                if (shadow_valid_q && (rd_data == shadow_q[addr_q])) begin
                    state_d = StNext;
                end else begin
                    shadow_we = 1'b1;
                    color_d   = pal_color;
                    state_d   = StStart;
                end
`else
                color_d = pal_color;
                state_d = StStart;
`endif
            end
            StStart: state_d = StWait;
            StWait: begin
                if (box_done) begin
                    state_d = StNext;
                end
            end
            StNext: begin
                if (last_cell) begin
                    state_d = StDone;
                end else begin
                    addr_d = addr_q + 8'd1;
                    if (col_q != ColW'(COLS - 1)) begin
                        col_en = 1'b1;
                        x_d    = x_q + 10'(CELL_W);
                    end else begin
                        col_load = 1'b1;
                        row_en   = 1'b1;
                        x_d      = X_ORIGIN;
                        y_d      = y_q + 9'(CELL_H);
                    end
                    state_d = StAddr;
                end
            end
            StDone: begin
`ifdef SKIP_UNCHANGED_EN
                shadow_valid_d = 1'b1;
`endif
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            x_q       <= '0;
            y_q       <= '0;
            color_q   <= '0;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            x_q       <= x_d;
            y_q       <= y_d;
            color_q   <= color_d;
            pending_q <= pending_d;
        end
    end

`ifdef SKIP_UNCHANGED_EN
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            shadow_valid_q <= 1'b0;
        end else begin
            shadow_valid_q <= shadow_valid_d;
        end
    end

    // Shadow contents need no reset: shadow_valid gates every use.
    always_ff @(posedge CLOCK_50) begin
        if (shadow_we) begin
            shadow_q[addr_q] <= rd_data;
        end
    end
`endif

    assign rd_addr    = addr_q;
    assign box_x0     = x_q;
    assign box_y0     = y_q;
    assign box_color  = color_q;
    assign box_start  = (state_q == StStart);
    assign frame_done = (state_q == StDone);
    assign busy       = (state_q != StIdle) && (state_q != StDone);

endmodule
